// File: rtl/ee354_gcd.sv
// Binary (Stein) GCD engine, 8-bit, Start/Ack handshake, clock enable.
// In: Clk Reset(n) CEN Start Ack Ain Bin. Out: A B AB_GCD i_count q_*.
module ee354_gcd (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       CEN,
    input  logic       Start,
    input  logic       Ack,
    input  logic [7:0] Ain,
    input  logic [7:0] Bin,
    output logic [7:0] A,
    output logic [7:0] B,
    output logic [7:0] AB_GCD,
    output logic [7:0] i_count,
    output logic       q_I,
    output logic       q_Sub,
    output logic       q_Mult,
    output logic       q_Done
);

    typedef enum logic [3:0] {
        QI    = 4'b0001,
        QSUB  = 4'b0010,
        QMULT = 4'b0100,
        QDONE = 4'b1000
    } state_t;

    state_t state;

    assign q_I    = state[0];
    assign q_Sub  = state[1];
    assign q_Mult = state[2];
    assign q_Done = state[3];

    // Where to go once the odd core of the GCD is known.
    state_t fin;
    assign fin = (i_count == 8'd0) ? QDONE : QMULT;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= QI;
            A       <= 8'd0;
            B       <= 8'd0;
            AB_GCD  <= 8'd0;
            i_count <= 8'd0;
        end else if (CEN) begin
            case (state)
                QI: begin
                    A       <= Ain;
                    B       <= Bin;
                    i_count <= 8'd0;
                    AB_GCD  <= 8'd0;
                    if (Start)
                        state <= QSUB;
                end
                QSUB: begin
                    if (A == B) begin
                        AB_GCD <= A;
                        state  <= fin;
                    end else if (A == 8'd0) begin
                        AB_GCD <= B;
                        state  <= fin;
                    end else if (B == 8'd0) begin
                        AB_GCD <= A;
                        state  <= fin;
                    end else if (!A[0] && !B[0]) begin
                        A       <= A >> 1;
                        B       <= B >> 1;
                        i_count <= i_count + 8'd1;
                    end else if (!A[0]) begin
                        A <= A >> 1;
                    end else if (!B[0]) begin
                        B <= B >> 1;
                    end else if (A > B) begin
                        A <= A - B;
                    end else begin
                        B <= B - A;
                    end
                end
                QMULT: begin
                    // Restore the common factors of two.
                    AB_GCD  <= AB_GCD << 1;
                    i_count <= i_count - 8'd1;
                    if (i_count == 8'd1)
                        state <= QDONE;
                end
                QDONE: begin
                    if (Ack)
                        state <= QI;
                end
                default: state <= QI;
            endcase
        end
    end

endmodule

// File: tb/tb_ee354_gcd.sv
// Directed bench for ee354_gcd.
// Vector table plus hand-written trace, hold, CEN and reset sequences.
module tb_ee354_gcd;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       CEN = 1'b1;
    logic       Start = 1'b0;
    logic       Ack = 1'b0;
    logic [7:0] Ain = 8'd0;
    logic [7:0] Bin = 8'd0;
    logic [7:0] A, B, AB_GCD, i_count;
    logic       q_I, q_Sub, q_Mult, q_Done;

    int tests = 0;
    int fails = 0;

    ee354_gcd dut (
        .Clk(Clk), .Reset(Reset), .CEN(CEN),
        .Start(Start), .Ack(Ack),
        .Ain(Ain), .Bin(Bin),
        .A(A), .B(B), .AB_GCD(AB_GCD),
        .i_count(i_count),
        .q_I(q_I), .q_Sub(q_Sub),
        .q_Mult(q_Mult), .q_Done(q_Done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] ain;
        logic [7:0] bin;
        logic [7:0] gcd;
        int         clks;
    } vec_t;

    // Expected register trace for gcd(36,24) after each q_Sub-entry clock.
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] i;
        logic [7:0] g;
        logic [3:0] st;
    } step_t;

    vec_t  vecs[9];
    step_t trc[8];

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] st();
        return {q_Done, q_Mult, q_Sub, q_I};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        Ain = a;
        Bin = b;
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!q_Done && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic do_ack();
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
    endtask

    task automatic chk_step(input string nm, input int k);
        chk({nm, " A"}, A, trc[k].a);
        chk({nm, " B"}, B, trc[k].b);
        chk({nm, " i"}, i_count, trc[k].i);
        chk({nm, " G"}, AB_GCD, trc[k].g);
        chk({nm, " st"}, st(), trc[k].st);
    endtask

    initial begin
        int n;
        logic [7:0] sa, sb, si, sg;
        logic [3:0] ss;
        int k;

        vecs[0] = '{8'd36, 8'd24, 8'd12, 8};
        vecs[1] = '{8'd5, 8'd15, 8'd5, 3};
        vecs[2] = '{8'd0, 8'd7, 8'd7, 1};
        vecs[3] = '{8'd0, 8'd0, 8'd0, 1};
        vecs[4] = '{8'd7, 8'd0, 8'd7, 1};
        vecs[5] = '{8'd13, 8'd13, 8'd13, 1};
        vecs[6] = '{8'd48, 8'd18, 8'd6, 8};
        vecs[7] = '{8'd255, 8'd1, 8'd1, 15};
        vecs[8] = '{8'd128, 8'd64, 8'd64, 14};

        trc[0] = '{8'd18, 8'd12, 8'd1, 8'd0, 4'b0010};
        trc[1] = '{8'd9, 8'd6, 8'd2, 8'd0, 4'b0010};
        trc[2] = '{8'd9, 8'd3, 8'd2, 8'd0, 4'b0010};
        trc[3] = '{8'd6, 8'd3, 8'd2, 8'd0, 4'b0010};
        trc[4] = '{8'd3, 8'd3, 8'd2, 8'd0, 4'b0010};
        trc[5] = '{8'd3, 8'd3, 8'd2, 8'd3, 4'b0100};
        trc[6] = '{8'd3, 8'd3, 8'd1, 8'd6, 4'b0100};
        trc[7] = '{8'd3, 8'd3, 8'd0, 8'd12, 4'b1000};

        #12;
        chk("rst st", st(), 4'b0001);
        chk("rst A", A, 0);
        chk("rst G", AB_GCD, 0);
        Reset = 1'b1;
        tick();

        // Table-driven vectors
        foreach (vecs[v]) begin
            start_op(vecs[v].ain, vecs[v].bin);
            chk($sformatf("v%0d sub", v), st(), 4'b0010);
            wait_done(n);
            chk($sformatf("v%0d clks", v), n, vecs[v].clks);
            chk($sformatf("v%0d gcd", v), AB_GCD, vecs[v].gcd);
            chk($sformatf("v%0d i", v), i_count, 0);
            do_ack();
            chk($sformatf("v%0d ack", v), st(), 4'b0001);
        end

        // Full register trace for gcd(36,24)
        start_op(8'd36, 8'd24);
        chk("tr A0", A, 36);
        chk("tr B0", B, 24);
        for (int j = 0; j < 8; j++) begin
            tick();
            chk_step($sformatf("tr%0d", j), j);
        end

        // Done holds while Ack low; Start ignored
        Start = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("hold st", st(), 4'b1000);
            chk("hold G", AB_GCD, 12);
        end
        Start = 1'b0;
        do_ack();
        chk("hold ack", st(), 4'b0001);

        // No q_Mult visit for gcd(5,15)
        start_op(8'd5, 8'd15);
        n = 0;
        k = 0;
        while (!q_Done && n < 50) begin
            tick();
            n++;
            if (q_Mult) k++;
        end
        chk("5,15 mult", k, 0);
        chk("5,15 clks", n, 3);
        do_ack();

        // CEN toggling stretches the same trace
        start_op(8'd36, 8'd24);
        k = 0;
        for (int j = 0; j < 16; j++) begin
            CEN = j[0];
            sa = A;
            sb = B;
            si = i_count;
            sg = AB_GCD;
            ss = st();
            tick();
            if (!CEN) begin
                chk("cen0 A", A, sa);
                chk("cen0 B", B, sb);
                chk("cen0 i", i_count, si);
                chk("cen0 G", AB_GCD, sg);
                chk("cen0 st", st(), ss);
            end else begin
                chk_step($sformatf("cen%0d", k), k);
                k++;
            end
        end
        CEN = 1'b1;
        do_ack();

        // Asynchronous reset mid-q_Sub
        start_op(8'd36, 8'd24);
        tick();
        tick();
        chk("mid sub", st(), 4'b0010);
        #2;
        Reset = 1'b0;
        #1;
        chk("arst st", st(), 4'b0001);
        chk("arst A", A, 0);
        chk("arst B", B, 0);
        chk("arst G", AB_GCD, 0);
        chk("arst i", i_count, 0);
        #1;
        Reset = 1'b1;
        #1;
        chk("rel st", st(), 4'b0001);
        chk("rel A", A, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim time exceeded, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ee354_gcd.md
Name: ee354_gcd

Overview:
- Multi-cycle 8-bit GCD engine with a Start/Ack handshake.
- Computes gcd(Ain, Bin) with a binary (Stein-style) algorithm: a subtract/shift phase, then a multiply-back phase that restores common factors of two.
- A clock enable (CEN) allows single-stepping from a top-level wrapper.
- State and datapath registers are exposed for display and debug.

Parameters:
- None. Datapath width is fixed at 8 bits.

Ports:
- Clk  input  1  system clock; all state and data updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- CEN  input  1  clock enable; when 0, all registers (state and data) hold.
- Start  input  1  level-sampled in q_I; begins a computation.
- Ack  input  1  level-sampled in q_Done; returns to q_I.
- Ain  input  8  operand A, loaded in q_I.
- Bin  input  8  operand B, loaded in q_I.
- A  output  8  working register A.
- B  output  8  working register B.
- AB_GCD  output  8  result register; valid in q_Done.
- i_count  output  8  count of common factors of two removed.
- q_I  output  1  one-hot state flag: Initial.
- q_Sub  output  1  one-hot state flag: Subtract/shift.
- q_Mult  output  1  one-hot state flag: Multiply-back.
- q_Done  output  1  one-hot state flag: Done.

Behaviour:
- Reset (Reset=0, async):
  - state = q_I.
  - A, B, AB_GCD, i_count = 0.
  - Reset overrides everything, including mid-computation; a computation in progress is aborted.
- Clock enable: all actions below occur only on rising Clk with CEN=1. When CEN=0, nothing changes.
- State flags: exactly one of q_I/q_Sub/q_Mult/q_Done is 1 at any time. Flags are decoded from registered state, not gated by CEN.
- q_I:
  - Every enabled clock: A<=Ain, B<=Bin, i_count<=0, AB_GCD<=0.
  - If Start=1, go to q_Sub; otherwise stay in q_I.
- q_Sub: one action per enabled clock, evaluated in this priority order:
  1. A==B: AB_GCD<=A. If i_count==0, go to q_Done; else go to q_Mult.
  2. A==0: AB_GCD<=B. Go to q_Done if i_count==0, else q_Mult.
  3. B==0: AB_GCD<=A. Go to q_Done if i_count==0, else q_Mult.
  4. A and B both even: A<=A>>1, B<=B>>1, i_count<=i_count+1.
  5. A even: A<=A>>1.
  6. B even: B<=B>>1.
  7. A>B: A<=A-B.
  8. Otherwise: B<=B-A.
- q_Mult:
  - Each enabled clock: AB_GCD<=AB_GCD<<1 and i_count<=i_count-1.
  - If i_count==1 (i.e. it becomes 0), go to q_Done; otherwise stay.
- q_Done:
  - Hold all registers.
  - If Ack=1, go to q_I; otherwise stay.
- Start outside q_I and Ack outside q_Done are ignored.
- Latency, counted in enabled clocks from entry into q_Sub to entry into q_Done = (number of q_Sub cycles) + (final i_count). Examples:
  - gcd(36,24): 8 clocks.
  - gcd(5,15): 3 clocks.
- Arithmetic:
  - Unsigned 8-bit throughout.
  - Subtraction never underflows because the larger operand is always reduced.
  - Results never overflow: the shifted GCD is at most max(Ain, Bin).
- Zero operands:
  - gcd(0,0) = 0.
  - gcd(x,0) = gcd(0,x) = x.
  - Neither case loops.

Test Plan:
- Reset low mid-q_Sub, then release -> q_I=1; A, B, AB_GCD, i_count = 0 immediately, without waiting for a clock edge.
- Ain=36, Bin=24, Start pulse -> sequence:
  - q_Sub 6 cycles: (18,12,i=1), (9,6,i=2), (9,3), (6,3), (3,3), equal.
  - q_Mult 2 cycles.
  - q_Done with AB_GCD=12, i_count=0; 8 clocks from q_Sub entry.
- Ain=5, Bin=15, Start pulse -> B: 10, 5, then equal -> q_Done with AB_GCD=5 after 3 clocks, with no q_Mult visit.
- In q_Done, hold Ack=0 for several clocks -> state and AB_GCD stable. Ack=1 for one clock -> q_I.
- Ain=0, Bin=7 -> AB_GCD=7. Ain=0, Bin=0 -> AB_GCD=0. Both reach q_Done in 1 clock.
- Ain=36, Bin=24 with CEN toggled 0/1 every other clock -> identical register sequence to the CEN=1 case, stretched; no change on any clock where CEN=0.
